mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Launches one bus transaction per
// aligned load/store, stalls the pipeline until it completes, formats load data
// and flags misaligned accesses without touching the bus.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MEM_MemRead_i,
    input  logic                  MEM_MemWrite_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
    input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
    output logic                  MEM_stall_o,
    output logic                  MEM_misaligned_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    op_s;
    logic                    is_read_s;
    logic                    misaligned_s;
    logic                    launch_s;
    logic                    stall_s;
    logic [2:0]              funct3_s;
    logic [1:0]              offs_s;
    logic                    unused_s;

    logic                    req_r;
    logic                    we_r;
    logic [DATA_WIDTH-1:0]   addr_r;
    logic [3:0]              be_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [2:0]              funct3_r;
    logic [1:0]              offs_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;

    // Size code is funct3[1:0]: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Selects the addressed lane and extends it; unknown funct3 behaves as LW.
    function automatic logic [DATA_WIDTH-1:0] load_format(input logic [DATA_WIDTH-1:0] w,
                                                           input logic [1:0] off,
                                                           input logic [2:0] f3);
        logic [DATA_WIDTH-1:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return w;
        endcase
    endfunction

    assign op_s         = MEM_MemRead_i | MEM_MemWrite_i;
    assign is_read_s    = MEM_MemRead_i;            // read wins when both are set
    assign funct3_s     = MEM_instruction_i[14:12];
    assign offs_s       = MEM_alu_result_i[1:0];
    assign misaligned_s = is_misaligned(funct3_s[1:0], offs_s);
    assign unused_s     = ^{MEM_instruction_i[31:15], MEM_instruction_i[11:0]};

    // Next-state and stall decode.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        launch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_s && !misaligned_s) begin
                    state_nxt_s = REQ;
                    stall_s     = 1'b1;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (dmem_gnt_i) begin
                    state_nxt_s = we_r ? DONE : WAIT_R;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_R: begin
                stall_s = 1'b1;
                if (dmem_rvalid_i) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_R;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and bus request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (launch_s) begin
                req_r <= 1'b1;
                we_r  <= ~is_read_s;
            end else if ((state_r == REQ) && dmem_gnt_i) begin
                req_r <= 1'b0;
            end
        end
    end

    // Request payload captured at launch and held until the transaction ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            be_r     <= 4'b0000;
            wdata_r  <= '0;
            funct3_r <= 3'b000;
            offs_r   <= 2'b00;
        end else if (launch_s) begin
            addr_r   <= {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
            be_r     <= is_read_s ? 4'b1111 : store_be(funct3_s[1:0], offs_s);
            wdata_r  <= is_read_s ? '0 : store_data(funct3_s[1:0], MEM_wr_data_i);
            funct3_r <= funct3_s;
            offs_r   <= offs_s;
        end
    end

    // Load result register; only a completing read updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if ((state_r == WAIT_R) && dmem_rvalid_i) begin
            rd_data_r <= load_format(dmem_rdata_i, offs_r, funct3_r);
        end
    end

    assign dmem_req_o       = req_r;
    assign dmem_we_o        = we_r;
    assign dmem_addr_o      = addr_r;
    assign dmem_be_o        = be_r;
    assign dmem_wdata_o     = wdata_r;
    assign MEM_rd_data_o    = rd_data_r;
    assign MEM_stall_o      = stall_s;
    assign MEM_misaligned_o = rst_n & (state_r == IDLE) & op_s & misaligned_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a bus responder with configurable grant and
// rvalid delays, a queue of expected load results, and scenario tasks.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_MemRead_i, MEM_MemWrite_i;
    logic [31:0] MEM_alu_result_i, MEM_wr_data_i, MEM_instruction_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] MEM_rd_data_o;
    logic        MEM_stall_o, MEM_misaligned_o;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
        .MEM_alu_result_i(MEM_alu_result_i), .MEM_wr_data_i(MEM_wr_data_i),
        .MEM_instruction_i(MEM_instruction_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .MEM_rd_data_o(MEM_rd_data_o), .MEM_stall_o(MEM_stall_o),
        .MEM_misaligned_o(MEM_misaligned_o)
    );

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] off, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) begin
            case (off)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (f3[1:0] == 2'b01) begin
            return off[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // One complete aligned transaction driven against the bus responder.
    task automatic run_op(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input bit noise);
        logic        read_op;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rd;
        int          exp_stall, stall_cnt, req_cnt, wait_cnt, cyc;
        bit          granted, rv_given, done;
        read_op   = rd;
        exp_be    = read_op ? 4'b1111 : model_be(addr[1:0], f3);
        exp_wdata = model_wdata(wd, f3);
        exp_stall = read_op ? (3 + gnt_dly + rv_dly) : (2 + gnt_dly);
        if (read_op) exp_q.push_back(model_load(rdata, addr[1:0], f3));
        @(negedge clk);
        MEM_MemRead_i     = rd;
        MEM_MemWrite_i    = wr;
        MEM_alu_result_i  = addr;
        MEM_wr_data_i     = wd;
        MEM_instruction_i = {17'h0, f3, 12'h003};
        dmem_rdata_i      = rdata;
        stall_cnt = 0; req_cnt = 0; wait_cnt = 0; cyc = 0;
        granted = 1'b0; rv_given = 1'b0; done = 1'b0;
        #1;
        tests++;
        if (MEM_misaligned_o !== 1'b0) begin
            fails++; $display("FAIL %s misaligned: got %b want 0", name, MEM_misaligned_o);
        end
        while (!done && cyc < 200) begin
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (MEM_stall_o === 1'b1) stall_cnt++;
            else done = 1'b1;
            if (!done) begin
                if (dmem_req_o === 1'b1) begin
                    req_cnt++;
                    tests++;
                    if ({dmem_addr_o, dmem_be_o, dmem_we_o} !== {addr & 32'hFFFF_FFFC, exp_be, ~read_op}) begin
                        fails++;
                        $display("FAIL %s bus: got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                                 name, dmem_addr_o, dmem_be_o, dmem_we_o,
                                 addr & 32'hFFFF_FFFC, exp_be, ~read_op);
                    end
                    if (!read_op) begin
                        tests++;
                        if (dmem_wdata_o !== exp_wdata) begin
                            fails++;
                            $display("FAIL %s wdata: got %h want %h", name, dmem_wdata_o, exp_wdata);
                        end
                    end
                    if (req_cnt > gnt_dly) begin
                        dmem_gnt_i = 1'b1; granted = 1'b1;
                    end else if (noise) begin
                        dmem_rvalid_i = 1'b1;
                    end
                end else if (granted && read_op && !rv_given) begin
                    wait_cnt++;
                    if (wait_cnt > rv_dly) begin
                        dmem_rvalid_i = 1'b1; rv_given = 1'b1;
                    end else if (noise) begin
                        dmem_gnt_i = 1'b1;
                    end
                end
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        tests++;
        if (!done) begin
            fails++; $display("FAIL %s timeout: stall still %b after %0d cycles", name, MEM_stall_o, cyc);
        end
        tests++;
        if (dmem_req_o !== 1'b0) begin
            fails++; $display("FAIL %s req_at_done: got %b want 0", name, dmem_req_o);
        end
        MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        tests++;
        if (stall_cnt != exp_stall) begin
            fails++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_stall);
        end
        tests++;
        if (req_cnt != gnt_dly + 1) begin
            fails++; $display("FAIL %s req_cycles: got %0d want %0d", name, req_cnt, gnt_dly + 1);
        end
        if (read_op) begin
            exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            last_rd = exp_rd;
        end else begin
            exp_rd = last_rd;
        end
        tests++;
        if (MEM_rd_data_o !== exp_rd) begin
            fails++; $display("FAIL %s rd_data: got %h want %h", name, MEM_rd_data_o, exp_rd);
        end
    endtask

    // Misaligned op held for one cycle: no request, no stall, pulse only while present.
    task automatic mis_one(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [2:0] f3);
        @(negedge clk);
        MEM_MemRead_i = rd; MEM_MemWrite_i = wr;
        MEM_alu_result_i = addr; MEM_wr_data_i = 32'h1234_5678;
        MEM_instruction_i = {17'h0, f3, 12'h003};
        #1;
        tests++;
        if ({MEM_misaligned_o, MEM_stall_o, dmem_req_o} !== 3'b100) begin
            fails++;
            $display("FAIL %s present: got mis/stall/req=%b%b%b want 100",
                     name, MEM_misaligned_o, MEM_stall_o, dmem_req_o);
        end
        @(negedge clk);
        tests++;
        if ({MEM_stall_o, dmem_req_o} !== 2'b00) begin
            fails++; $display("FAIL %s after_edge: got stall/req=%b%b want 00", name, MEM_stall_o, dmem_req_o);
        end
        MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0;
        #1;
        tests++;
        if ({MEM_misaligned_o, MEM_rd_data_o} !== {1'b0, last_rd}) begin
            fails++;
            $display("FAIL %s cleared: got mis=%b rd=%h want mis=0 rd=%h",
                     name, MEM_misaligned_o, MEM_rd_data_o, last_rd);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        MEM_MemRead_i = 1'b1; MEM_MemWrite_i = 1'b0;
        MEM_alu_result_i = 32'h0000_0102; MEM_wr_data_i = 32'h0;
        MEM_instruction_i = 32'h0000_2003;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        tests++;
        if ({dmem_req_o, dmem_we_o, MEM_misaligned_o, MEM_rd_data_o} !== 35'h0) begin
            fails++;
            $display("FAIL reset: got req=%b we=%b mis=%b rd=%h want all 0",
                     dmem_req_o, dmem_we_o, MEM_misaligned_o, MEM_rd_data_o);
        end
        MEM_MemRead_i = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if ({MEM_stall_o, dmem_req_o} !== 2'b00) begin
            fails++; $display("FAIL reset_idle: got stall/req=%b%b want 00", MEM_stall_o, dmem_req_o);
        end
    endtask

    task automatic test_lw_basic;
        run_op("lw_0x100", 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_store_lanes;
        run_op("sb_0x103", 1'b0, 1'b1, 32'h103, 32'h0000_00A5, 3'b000, 0, 0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_op("sb_lane", 1'b0, 1'b1, 32'h200 + i, 32'hFFFF_FF3C + i, 3'b000, 0, 0, 32'h0, 1'b0);
        run_op("sh_0x100", 1'b0, 1'b1, 32'h100, 32'hABCD_1234, 3'b001, 0, 0, 32'h0, 1'b0);
        run_op("sh_0x102", 1'b0, 1'b1, 32'h102, 32'h0000_BEEF, 3'b001, 1, 0, 32'h0, 1'b0);
        run_op("sw_0x104", 1'b0, 1'b1, 32'h104, 32'h1357_9BDF, 3'b010, 0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_load_formats;
        run_op("lh_0x102", 1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 0, 32'h8001_FFFF, 1'b0);
        run_op("lhu_0x102", 1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 0, 0, 32'h8001_FFFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("lb_lane", 1'b1, 1'b0, 32'h300 + i, 32'h0, 3'b000, 0, 1, 32'h80FF_7F01, 1'b0);
            run_op("lbu_lane", 1'b1, 1'b0, 32'h300 + i, 32'h0, 3'b100, 1, 0, 32'h80FF_7F01, 1'b0);
        end
        run_op("lh_0x100", 1'b1, 1'b0, 32'h100, 32'h0, 3'b001, 0, 0, 32'h1234_F00D, 1'b0);
        run_op("f3_011_as_lw", 1'b1, 1'b0, 32'h108, 32'h0, 3'b011, 0, 0, 32'hA5A5_0F0F, 1'b0);
        run_op("f3_110_as_lw", 1'b1, 1'b0, 32'h10C, 32'h0, 3'b110, 0, 0, 32'h0123_4567, 1'b0);
    endtask

    task automatic test_misaligned;
        mis_one("mis_lw_0x102", 1'b1, 1'b0, 32'h102, 3'b010);
        mis_one("mis_lh_0x101", 1'b1, 1'b0, 32'h101, 3'b001);
        mis_one("mis_sw_0x101", 1'b0, 1'b1, 32'h101, 3'b010);
        mis_one("mis_sh_0x103", 1'b0, 1'b1, 32'h103, 3'b001);
    endtask

    task automatic test_grant_stall;
        run_op("sw_gnt5", 1'b0, 1'b1, 32'h400, 32'hC0FF_EE11, 3'b010, 5, 0, 32'h0, 1'b0);
        run_op("lw_gnt5_rv3_noise", 1'b1, 1'b0, 32'h404, 32'h0, 3'b010, 5, 3, 32'h7654_3210, 1'b1);
        run_op("sb_gnt2_noise", 1'b0, 1'b1, 32'h409, 32'h0000_0066, 3'b000, 2, 0, 32'h0, 1'b1);
    endtask

    task automatic test_rd_wr_both;
        run_op("rd_and_wr", 1'b1, 1'b1, 32'h500, 32'hFFFF_FFFF, 3'b010, 0, 0, 32'h5A5A_A5A5, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 8; i++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            a  = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            if (i[0]) run_op("b2b_load", 1'b1, 1'b0, a, 32'h0, f3,
                             $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
            else if (!f3[2]) run_op("b2b_store", 1'b0, 1'b1, a, $urandom, f3,
                                    $urandom_range(0, 2), 0, 32'h0, 1'b0);
            else run_op("b2b_load", 1'b1, 1'b0, a, 32'h0, f3, 0, 0, $urandom, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        run_op("lw_before_rst", 1'b1, 1'b0, 32'h600, 32'h0, 3'b010, 0, 0, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        MEM_MemRead_i = 1'b1; MEM_MemWrite_i = 1'b0;
        MEM_alu_result_i = 32'h200; MEM_instruction_i = 32'h0000_2003;
        dmem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (dmem_req_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_req: got %b want 1", dmem_req_o);
        end
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        tests++;
        if ({MEM_stall_o, dmem_req_o} !== 2'b10) begin
            fails++; $display("FAIL rstmid_wait: got stall/req=%b%b want 10", MEM_stall_o, dmem_req_o);
        end
        rst_n = 1'b0;
        MEM_MemRead_i = 1'b0;
        #1;
        tests++;
        if ({dmem_req_o, dmem_we_o, MEM_rd_data_o} !== 34'h0) begin
            fails++;
            $display("FAIL rstmid_clear: got req=%b we=%b rd=%h want 0", dmem_req_o, dmem_we_o, MEM_rd_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'h0;
        dmem_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({MEM_stall_o, dmem_req_o, MEM_rd_data_o} !== 34'h0) begin
                fails++;
                $display("FAIL rstmid_late_rvalid: got stall=%b req=%b rd=%h want 0 0 0",
                         MEM_stall_o, dmem_req_o, MEM_rd_data_o);
            end
        end
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_store_lanes();
        test_load_formats();
        test_misaligned();
        test_grant_stall();
        test_rd_wr_both();
        test_back_to_back();
        test_reset_mid();
        run_op("lw_after_rst", 1'b1, 1'b0, 32'h700, 32'h0, 3'b010, 0, 0, 32'h0BAD_CAFE, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
